// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the write-back unit.
package ysyx_25060170_pkg;

  // Write-back FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } wbu_state_t;

  // Load funct3 encodings; any other code is handled as a full word
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_25060170_load_ext.sv
// Selects the byte/halfword lane of a read word and sign/zero-extends it.
module ysyx_25060170_load_ext
  import ysyx_25060170_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rdata,
  input  logic [1:0]    i_lane,
  input  logic [2:0]    i_funct3,
  output logic [DW-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane pick: byte by addr[1:0], halfword by addr[1] only
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension; unlisted funct3 codes fall through to the whole word
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:  o_data = {{(DW-8){w_byte[7]}}, w_byte};
      F3_LH:  o_data = {{(DW-16){w_half[15]}}, w_half};
      F3_LBU: o_data = {{(DW-8){1'b0}}, w_byte};
      F3_LHU: o_data = {{(DW-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: accepts one retired op, performs the load read if needed,
// and drives a single-cycle GPR write plus a commit pulse.
module ysyx_25060170_wbu
  import ysyx_25060170_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_ld_addr,
  input  logic [2:0]    ex_ld_funct3,
  input  logic [DW-1:0] ex_pc,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          gpr_we,
  output logic [RW-1:0] gpr_waddr,
  output logic [DW-1:0] gpr_wd,
  output logic          wb_done,
  output logic [DW-1:0] wb_pc
);

  wbu_state_t    r_state;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_pc;
  logic [1:0]    r_lane;
  logic [2:0]    r_funct3;
  logic [AW-1:0] r_mem_addr;
  logic [RW-1:0] r_gpr_waddr;
  logic [DW-1:0] r_gpr_wd;
  logic [DW-1:0] r_wb_pc;
  logic          w_accept;
  logic [DW-1:0] w_ext;

  assign w_accept = ex_valid && (r_state == S_IDLE);

  ysyx_25060170_load_ext #(.DW(DW)) u_load_ext (
    .i_rdata  (mem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  // FSM plus op latches; the GPR-facing registers only change on entry to WB
  // so waddr/wd/pc hold their last committed value the rest of the time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd        <= '0;
      r_pc        <= '0;
      r_lane      <= '0;
      r_funct3    <= '0;
      r_mem_addr  <= '0;
      r_gpr_waddr <= '0;
      r_gpr_wd    <= '0;
      r_wb_pc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rd     <= ex_rd;
          r_pc     <= ex_pc;
          r_lane   <= ex_ld_addr[1:0];
          r_funct3 <= ex_ld_funct3;
          if (ex_is_load) begin
            r_mem_addr <= {ex_ld_addr[AW-1:2], 2'b00};
            r_state    <= S_REQ;
          end else begin
            r_gpr_waddr <= ex_rd;
            r_gpr_wd    <= ex_result;
            r_wb_pc     <= ex_pc;
            r_state     <= S_WB;
          end
        end
        S_REQ: if (mem_req_ready) r_state <= S_WAIT;
        S_WAIT: if (mem_rsp_valid) begin
          r_gpr_waddr <= r_rd;
          r_gpr_wd    <= w_ext;
          r_wb_pc     <= r_pc;
          r_state     <= S_WB;
        end
        S_WB: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready      = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_mem_addr;
  assign wb_done       = (r_state == S_WB);
  assign gpr_we        = (r_state == S_WB) && (r_gpr_waddr != '0);
  assign gpr_waddr     = r_gpr_waddr;
  assign gpr_wd        = r_gpr_wd;
  assign wb_pc         = r_wb_pc;

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Self-checking bench for the write-back unit.
module tb_ysyx_25060170_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [31:0] ex_ld_addr;
  logic [2:0]  ex_ld_funct3;
  logic [31:0] ex_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wd;
  logic        wb_done;
  logic [31:0] wb_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25060170_wbu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_is_load(ex_is_load), .ex_ld_addr(ex_ld_addr), .ex_ld_funct3(ex_ld_funct3), .ex_pc(ex_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd),
    .wb_done(wb_done), .wb_pc(wb_pc)
  );

  // Reference load result: shift the chosen lane down, then extend arithmetically
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int unsigned b, h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  task automatic scramble_inputs();
    ex_rd = 5'($urandom); ex_result = $urandom; ex_ld_addr = $urandom;
    ex_ld_funct3 = 3'($urandom); ex_pc = $urandom; ex_is_load = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  // Quiet checks for a non-WB cycle
  task automatic chk_quiet(input string nm, input logic exp_rdy, input logic exp_req);
    total++;
    if (gpr_we !== 1'b0 || wb_done !== 1'b0 || ex_ready !== exp_rdy || mem_req_valid !== exp_req) begin
      bad++;
      $display("FAIL %s: we=%b done=%b rdy=%b req=%b, want we=0 done=0 rdy=%b req=%b",
               nm, gpr_we, wb_done, ex_ready, mem_req_valid, exp_rdy, exp_req);
    end
  endtask

  // Drive one op through the unit and check every cycle against the reference
  task automatic run_op(input string nm, input logic [4:0] rd, input logic [31:0] res,
                        input logic ld, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] rdata,
                        input int req_wait, input int rsp_wait);
    logic [31:0] exp_wd;
    @(negedge clk);
    total++;
    if (ex_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready: got %b want 1", nm, ex_ready); end
    ex_valid = 1'b1; ex_rd = rd; ex_result = res; ex_is_load = ld;
    ex_ld_addr = addr; ex_ld_funct3 = f3; ex_pc = pc;
    @(posedge clk); #1;
    ex_valid = 1'b0; scramble_inputs();
    exp_wd = ld ? ref_load(rdata, addr, f3) : res;
    if (ld) begin
      for (int k = 0; k <= req_wait; k++) begin
        @(negedge clk);
        chk_quiet({nm, " req"}, 1'b0, 1'b1);
        total++;
        if (mem_addr !== {addr[31:2], 2'b00}) begin
          bad++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, {addr[31:2], 2'b00});
        end
        mem_req_ready = (k == req_wait);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
      end
      for (int k = 1; k <= rsp_wait; k++) begin
        @(negedge clk);
        chk_quiet({nm, " wait"}, 1'b0, 1'b0);
        if (k == rsp_wait) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    total++;
    if (gpr_we !== (rd != 0) || wb_done !== 1'b1 || ex_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL %s wb_ctl: we=%b done=%b rdy=%b req=%b want we=%b done=1 rdy=0 req=0",
                      nm, gpr_we, wb_done, ex_ready, mem_req_valid, rd != 0);
    end
    total++;
    if (gpr_waddr !== rd || gpr_wd !== exp_wd || wb_pc !== pc) begin
      bad++; $display("FAIL %s wb_data: waddr=%0d wd=%h pc=%h want waddr=%0d wd=%h pc=%h",
                      nm, gpr_waddr, gpr_wd, wb_pc, rd, exp_wd, pc);
    end
    @(negedge clk);
    chk_quiet({nm, " after"}, 1'b1, 1'b0);
    total++;
    if (gpr_waddr !== rd || gpr_wd !== exp_wd || wb_pc !== pc) begin
      bad++; $display("FAIL %s hold: waddr=%0d wd=%h pc=%h want waddr=%0d wd=%h pc=%h",
                      nm, gpr_waddr, gpr_wd, wb_pc, rd, exp_wd, pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1 mem_rsp_valid = 1'b1;  // ignored in IDLE
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset", 1'b1, 1'b0);
    total++;
    if (gpr_waddr !== 5'd0 || gpr_wd !== 32'd0 || wb_pc !== 32'd0 || mem_addr !== 32'd0) begin
      bad++; $display("FAIL reset regs: waddr=%0d wd=%h pc=%h addr=%h want all 0",
                      gpr_waddr, gpr_wd, wb_pc, mem_addr);
    end
    @(negedge clk);
    chk_quiet("reset stale rsp", 1'b1, 1'b0);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_nonload();
    run_op("nonload", 5'd5, 32'h1234_5678, 1'b0, 32'h0, 3'b0, 32'h8000_0100, 32'h0, 0, 1);
    run_op("rd0", 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 3'b0, 32'h8000_0104, 32'h0, 0, 1);
  endtask

  task automatic test_loads();
    run_op("lb",  5'd1, 32'h0, 1'b1, 32'h8000_0003, 3'b000, 32'h8000_0200, 32'h80FF_0000, 0, 1);
    run_op("lbu", 5'd2, 32'h0, 1'b1, 32'h8000_0003, 3'b100, 32'h8000_0204, 32'h80FF_0000, 0, 1);
    run_op("lh",  5'd3, 32'h0, 1'b1, 32'h8000_0002, 3'b001, 32'h8000_0208, 32'h8001_7FFF, 0, 1);
    run_op("lhu", 5'd4, 32'h0, 1'b1, 32'h8000_0000, 3'b101, 32'h8000_020C, 32'h8001_7FFF, 0, 1);
    run_op("lw",  5'd6, 32'h0, 1'b1, 32'h8000_0001, 3'b010, 32'h8000_0210, 32'hDEAD_BEEF, 0, 1);
    run_op("f3_7",5'd7, 32'h0, 1'b1, 32'h8000_0002, 3'b111, 32'h8000_0214, 32'hCAFE_F00D, 0, 1);
  endtask

  task automatic test_backpressure();
    run_op("bp", 5'd9, 32'h0, 1'b1, 32'h9000_0006, 3'b001, 32'h8000_0300, 32'hA5A5_1234, 3, 2);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    ex_valid = 1'b1; ex_rd = 5'd10; ex_is_load = 1'b1; ex_ld_addr = 32'h8000_0010;
    ex_ld_funct3 = 3'b010; ex_pc = 32'h8000_0400;
    @(posedge clk); #1 ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0;   // now waiting for the response
    rst = 1'b1; #1;
    chk_quiet("rst_midop immediate", 1'b1, 1'b0);
    @(posedge clk); #1 rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_quiet("rst_midop stale", 1'b1, 1'b0);
      mem_rsp_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 5) == 5) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
      run_op("rand", 5'($urandom), $urandom, 1'($urandom), $urandom, f3, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3));
    end
  endtask

  // Back-to-back ops: second op offered right after the first commits
  task automatic test_back_to_back();
    run_op("b2b0", 5'd11, 32'h0000_0AAA, 1'b0, 32'h0, 3'b0, 32'h8000_0500, 32'h0, 0, 1);
    run_op("b2b1", 5'd12, 32'h0000_0BBB, 1'b0, 32'h0, 3'b0, 32'h8000_0504, 32'h0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_loads();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
